// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_ctrl block: default geometry, the
// extra-bit pointer type and the full-compare helper.
package fifo_pkg;

   localparam int DEFAULT_MEMORY_DEPTH = 4;
   localparam int DEFAULT_ADDRESS_SIZE = 2;

   typedef logic [DEFAULT_ADDRESS_SIZE:0] ptr_t;

   // The FIFO is full when the pointers sit on the same slot but the write
   // pointer has lapped the read pointer once (MSBs differ).
   function automatic logic ptr_full(input ptr_t w, input ptr_t r);
      return (w[DEFAULT_ADDRESS_SIZE] != r[DEFAULT_ADDRESS_SIZE]) &&
             (w[DEFAULT_ADDRESS_SIZE-1:0] == r[DEFAULT_ADDRESS_SIZE-1:0]);
   endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between the requesting logic (master) and the
// FIFO control block (slave), including the storage-array control lines.
interface fifo_ctrl_if
   import fifo_pkg::*;
#(
   parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE
);

   logic                    wr_req;
   logic                    rd_req;
   logic                    mem_we;
   logic [ADDRESS_SIZE-1:0] mem_waddr;
   logic                    mem_re;
   logic [ADDRESS_SIZE-1:0] mem_raddr;
   logic                    rd_valid;
   logic                    full;
   logic                    empty;
   logic                    almost_full;
   logic                    almost_empty;
   logic [ADDRESS_SIZE:0]   count;
   logic                    overflow;
   logic                    underflow;

   modport master (
      output wr_req, rd_req,
      input  mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty,
             almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wr_req, rd_req,
      output mem_we, mem_waddr, mem_re, mem_raddr, rd_valid, full, empty,
             almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_ptr_counter.sv
// Enabled binary pointer counter with synchronous active-low clear. Wraps
// naturally at 2**WIDTH, which is what the extra-bit full/empty scheme needs.
module fifo_ptr_counter
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_ADDRESS_SIZE + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   // Advance by one on each accepted operation; clear overrides the enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control block: qualifies push/pop against full/empty, drives the
// storage-array enables and addresses, and reports occupancy and errors.
// Build option FIFO_CTRL_STICKY_ERR_EN: when defined, overflow/underflow
// latch until reset; otherwise they pulse for one cycle per bad request.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
   parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
   parameter int AF_LEVEL     = 3,
   parameter int AE_LEVEL     = 1
) (
   input logic        clk,
   input logic        rst_n,
   fifo_ctrl_if.slave bus
);

   localparam int PW = ADDRESS_SIZE + 1;
   localparam logic [ADDRESS_SIZE:0] AF_THRESH = PW'(AF_LEVEL);
   localparam logic [ADDRESS_SIZE:0] AE_THRESH = PW'(AE_LEVEL);

   logic [ADDRESS_SIZE:0] w_wPtr;
   logic [ADDRESS_SIZE:0] w_rPtr;
   logic [ADDRESS_SIZE:0] w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pushOk;
   logic                  w_popOk;
   logic                  w_overflowHit;
   logic                  w_underflowHit;
   logic                  r_rdValid;
   logic                  r_overflow;
   logic                  r_underflow;

   if (MEMORY_DEPTH != (1 << ADDRESS_SIZE)) begin : gDepthCheck
      $error("fifo_ctrl: MEMORY_DEPTH must equal 2**ADDRESS_SIZE");
   end

   if (ADDRESS_SIZE == DEFAULT_ADDRESS_SIZE) begin : gPkgFull
      assign w_full = ptr_full(ptr_t'(w_wPtr), ptr_t'(w_rPtr));
   end else begin : gGenericFull
      assign w_full = (w_wPtr[ADDRESS_SIZE] != w_rPtr[ADDRESS_SIZE]) &&
                      (w_wPtr[ADDRESS_SIZE-1:0] == w_rPtr[ADDRESS_SIZE-1:0]);
   end

   assign w_empty        = (w_wPtr == w_rPtr);
   assign w_count        = w_wPtr - w_rPtr;
   assign w_pushOk       = bus.wr_req & ~w_full;
   assign w_popOk        = bus.rd_req & ~w_empty;
   assign w_overflowHit  = bus.wr_req & w_full;
   assign w_underflowHit = bus.rd_req & w_empty;

   fifo_ptr_counter #(.WIDTH(PW)) uWrPtr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_pushOk),
      .o_count (w_wPtr)
   );

   fifo_ptr_counter #(.WIDTH(PW)) uRdPtr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_popOk),
      .o_count (w_rPtr)
   );

   // Read data leaves the registered-read array one cycle after the pop, and
   // error flags report the request that hit a full/empty FIFO last cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdValid   <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_rdValid   <= w_popOk;
`ifdef FIFO_CTRL_STICKY_ERR_EN
         r_overflow  <= r_overflow | w_overflowHit;
         r_underflow <= r_underflow | w_underflowHit;
`else
         r_overflow  <= w_overflowHit;
         r_underflow <= w_underflowHit;
`endif
      end
   end

   assign bus.mem_we       = w_pushOk;
   assign bus.mem_waddr    = w_wPtr[ADDRESS_SIZE-1:0];
   assign bus.mem_re       = w_popOk;
   assign bus.mem_raddr    = w_rPtr[ADDRESS_SIZE-1:0];
   assign bus.rd_valid     = r_rdValid;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.almost_full  = (w_count >= AF_THRESH);
   assign bus.almost_empty = (w_count <= AE_THRESH);
   assign bus.count        = w_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control block for the team's synchronous FIFO built on (ADDRESS_SIZE+1)-bit "extra-bit" pointers.
- Accepts push/pop requests and qualifies them against full/empty.
- Drives the memory write enable and the read/write addresses, and produces full, empty, occupancy, read-valid and error flags.
- Sits between the requesting logic and the dual-port FIFO storage array.

Parameters:
- MEMORY_DEPTH, 4, number of FIFO entries; must equal 2**ADDRESS_SIZE.
- ADDRESS_SIZE, 2, memory address width; pointers are ADDRESS_SIZE+1 bits wide.
- AF_LEVEL, 3, count at or above which almost_full is asserted.
- AE_LEVEL, 1, count at or below which almost_empty is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wr_req  input  1  push request; data is presented to the memory in the same cycle.
- rd_req  input  1  pop request.
- mem_we  output  1  memory write enable (combinational: wr_req & ~full).
- mem_waddr  output  ADDRESS_SIZE  write address (w_ptr[ADDRESS_SIZE-1:0]).
- mem_re  output  1  memory read enable (combinational: rd_req & ~empty).
- mem_raddr  output  ADDRESS_SIZE  read address (r_ptr[ADDRESS_SIZE-1:0]).
- rd_valid  output  1  read data valid; asserted one cycle after an accepted pop.
- full  output  1  FIFO holds MEMORY_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDRESS_SIZE+1  current occupancy, range 0..MEMORY_DEPTH.
- overflow  output  1  push attempted while full.
- underflow  output  1  pop attempted while empty.

Behaviour:
- Reset: synchronous, active-low on rst_n.
  - Registered state clears to w_ptr=0, r_ptr=0, rd_valid=0, overflow=0, underflow=0.
  - Derived outputs at reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0.
  - Reset asserted mid-operation discards all contents at the next edge and overrides any request in that cycle.
- Pointers: w_ptr and r_ptr are (ADDRESS_SIZE+1)-bit binary counters.
  - Each increments by 1 on an accepted operation only.
  - Natural wrap-around: after 2*MEMORY_DEPTH-1 comes 0. No explicit compare-and-clear.
- Flags (combinational from the registered pointers):
  - empty = (w_ptr == r_ptr).
  - full = (MSBs differ) && (low ADDRESS_SIZE bits equal).
  - count = w_ptr - r_ptr, computed modulo 2**(ADDRESS_SIZE+1).
- Accept rules:
  - push_ok = wr_req & ~full.
  - pop_ok = rd_req & ~empty.
  - Both are decided on the pre-edge flags.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: push rejected, pop accepted; no read-during-write on the same address.
  - Empty: pop rejected, push accepted; no bypass path, data readable from the next cycle.
- Read latency: the memory is registered-read. rd_valid(t+1) = pop_ok(t).
- Errors, default behaviour (pulse):
  - overflow(t+1) = wr_req & full.
  - underflow(t+1) = rd_req & empty.
  - Each is a single-cycle pulse per offending request.
  - Pointers never move on a rejected request.

Optional Feature:
- Macro: FIFO_CTRL_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky. Once set they remain 1 until rst_n is asserted.
- Undefined: both are single-cycle pulses, as described in Behaviour.

Decomposition:
- Shared package fifo_pkg holds:
  - DEFAULT_MEMORY_DEPTH and DEFAULT_ADDRESS_SIZE.
  - A ptr_t typedef of width ADDRESS_SIZE+1.
  - A function ptr_full(w,r) returning the full-compare result.
- One sub-module: fifo_ptr_counter, instantiated twice (write and read).
  - Enabled increment counter of width ADDRESS_SIZE+1.
  - Synchronous active-low clear.

Test Plan (defaults: depth 4, AF_LEVEL 3, AE_LEVEL 1):
- Reset then idle -> empty=1, full=0, count=0, almost_empty=1, rd_valid=0, overflow=0, underflow=0.
- 4 consecutive pushes -> count 1,2,3,4; almost_full from count 3; full=1 with w_ptr=4 (3'b100) and r_ptr=0. A 5th push gives mem_we=0, overflow pulses for 1 cycle, w_ptr stays 4.
- From full, 4 pops -> mem_raddr 0,1,2,3; rd_valid high one cycle after each pop; empty=1 with both pointers at 4. A further pop gives mem_re=0 and an underflow pulse.
- 10 push-then-pop pairs -> pointers wrap 7->0; empty stays correct across the wrap; mem_waddr sequence 0,1,2,3,0,1,...
- Simultaneous push+pop at count 2 -> count stays 2 and both pointers advance. At full: only the pop is taken and count goes 4->3. At empty: only the push is taken and count goes 0->1 with no rd_valid.
- Reset asserted at count 3 during a push -> next cycle count=0 and empty=1. With FIFO_CTRL_STICKY_ERR_EN, overflow stays 1 after a single overflow until this reset clears it.
